// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner.
// Frame-synchronous (tear-free) update, brightness PWM, per-digit decimal point,
// leading-zero blanking and per-digit blink. All outputs are registered.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned DIV_W          = 15,
  parameter int unsigned BLINK_DIV_W    = 6,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blink_en,
  input  logic                    i_blank_lz,
  input  logic [3:0]              i_bright,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic                    o_frame
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  // XOR masks: applying them to an active-high pattern yields pin polarity,
  // and on their own they are the "everything off" pin value.
  localparam logic [7:0] SegOff = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SelOff =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_W-1:0]        div_q;
  logic [IdxW-1:0]         idx_q;
  logic [BLINK_DIV_W-1:0]  blink_q;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, disp_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
  logic [NUM_DIGITS-1:0]   shadow_bl_q, disp_bl_q;
  logic                    pending_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_q;

  logic tick, boundary;
  assign tick     = &div_q;
  assign boundary = tick && (idx_q == LastIdx);

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'h3F;
      4'h1:    f = 7'h06;
      4'h2:    f = 7'h5B;
      4'h3:    f = 7'h4F;
      4'h4:    f = 7'h66;
      4'h5:    f = 7'h6D;
      4'h6:    f = 7'h7D;
      4'h7:    f = 7'h07;
      4'h8:    f = 7'h7F;
      4'h9:    f = 7'h6F;
      4'hA:    f = 7'h77;
      4'hB:    f = 7'h7C;
      4'hC:    f = 7'h39;
      4'hD:    f = 7'h5E;
      4'hE:    f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Slot divider, digit index and per-frame blink counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      idx_q   <= '0;
      blink_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
      if (tick) begin
        idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end
      if (boundary) begin
        blink_q <= blink_q + 1'b1;
      end
    end
  end

  // Bus-side shadow copy; last write wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_bl_q   <= '0;
    end else if (cs) begin
      shadow_data_q <= i_data;
      shadow_dp_q   <= i_dp;
      shadow_bl_q   <= i_blink_en;
    end
  end

  // Display copy only moves at frame boundaries so a frame never mixes old and new data.
  // A write landing on the boundary itself keeps pending set for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      disp_bl_q   <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (boundary && pending_q) begin
        disp_data_q <= shadow_data_q;
        disp_dp_q   <= shadow_dp_q;
        disp_bl_q   <= shadow_bl_q;
      end
      if (cs) begin
        pending_q <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Next segment/select pattern for the current digit, blanking and PWM applied.
  always_comb begin
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_bl, cur_lz, run_zero, pwm_on, lit;
    logic [NUM_DIGITS-1:0] onehot;
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_bl   = 1'b0;
    cur_lz   = 1'b0;
    onehot   = '0;
    run_zero = 1'b1;
    // Walk from the top digit down so run_zero means "this and all higher nibbles are zero".
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      run_zero = run_zero && (disp_data_q[4*k +: 4] == 4'h0);
      if (idx_q == IdxW'(k)) begin
        cur_nib   = disp_data_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_bl    = disp_bl_q[k];
        cur_lz    = run_zero && (k != 0);
        onehot[k] = 1'b1;
      end
    end
    pwm_on = div_q[DIV_W-1 -: 4] <= i_bright;
    lit    = pwm_on && !(i_blank_lz && cur_lz) && !(blink_q[BLINK_DIV_W-1] && cur_bl);
    seg_d  = lit ? ({cur_dp, hex_font(cur_nib)} ^ SegOff) : SegOff;
    sel_d  = lit ? (onehot ^ SelOff) : SelOff;
  end

  // Output registers: seg and sel always switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= SegOff;
      sel_q   <= SelOff;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      frame_q <= boundary;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-position model of the scanner plus directed
// scenarios with literal expectations.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BW = 1;
  localparam int unsigned SlotLen  = 1 << DW;
  localparam int unsigned FrameLen = SlotLen * ND;
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset;
  logic        cs = 1'b0;
  logic [15:0] i_data = '0;
  logic [3:0]  i_dp = '0;
  logic [3:0]  i_blink_en = '0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  i_bright = 4'd15;
  logic [7:0]  o_seg;
  logic [3:0]  o_sel;
  logic        o_frame;

  int total = 0;
  int bad   = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS    (ND),
    .DIV_W         (DW),
    .BLINK_DIV_W   (BW),
    .SEG_ACTIVE_LOW(1),
    .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .i_data    (i_data),
    .i_dp      (i_dp),
    .i_blink_en(i_blink_en),
    .i_blank_lz(i_blank_lz),
    .i_bright  (i_bright),
    .o_seg     (o_seg),
    .o_sel     (o_sel),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // p = clock edges since reset release; the state the outputs reflect after edge p
  // is the scan position p (div = p mod slot, digit = slot number mod ND).
  int unsigned p = 0;
  logic [15:0] m_sh_data = '0, m_disp_data = '0;
  logic [3:0]  m_sh_dp = '0, m_disp_dp = '0, m_sh_bl = '0, m_disp_bl = '0;
  bit          m_pending = 1'b0;
  int unsigned m_div, m_idx;
  logic [3:0]  m_nib;
  bit          m_lz, m_on, m_phase, m_lit, m_bound;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_sel = 4'hF;
  logic        exp_frame = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      p = 0;
      m_sh_data = '0; m_disp_data = '0;
      m_sh_dp = '0; m_disp_dp = '0; m_sh_bl = '0; m_disp_bl = '0;
      m_pending = 1'b0;
      exp_seg = 8'hFF; exp_sel = 4'hF; exp_frame = 1'b0;
    end else begin
      m_div   = p % SlotLen;
      m_idx   = (p / SlotLen) % ND;
      m_phase = (((p / FrameLen) >> (BW - 1)) & 1) != 0;
      m_nib   = 4'(m_disp_data >> (4 * m_idx));
      m_lz    = i_blank_lz && (m_idx != 0) && ((m_disp_data >> (4 * m_idx)) == 16'h0);
      m_on    = (m_div >> (DW - 4)) <= 32'(i_bright);
      m_lit   = m_on && !m_lz && !(m_phase && m_disp_bl[m_idx]);
      if (m_lit) begin
        exp_sel = ~(4'b0001 << m_idx);
        exp_seg = ~{m_disp_dp[m_idx], FONT[m_nib]};
      end else begin
        exp_sel = 4'hF;
        exp_seg = 8'hFF;
      end
      m_bound   = (p % FrameLen) == FrameLen - 1;
      exp_frame = m_bound;
      if (m_bound && m_pending) begin
        m_disp_data = m_sh_data; m_disp_dp = m_sh_dp; m_disp_bl = m_sh_bl;
      end
      if (cs) m_pending = 1'b1;
      else if (m_bound) m_pending = 1'b0;
      if (cs) begin
        m_sh_data = i_data; m_sh_dp = i_dp; m_sh_bl = i_blink_en;
      end
      p++;
    end
  end

  // Compare every cycle, half a period away from the active edge.
  initial forever begin
    @(negedge clk);
    check("model_seg", 32'(o_seg), 32'(exp_seg));
    check("model_sel", 32'(o_sel), 32'(exp_sel));
    check("model_frame", 32'(o_frame), 32'(exp_frame));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    cs = 1'b1; i_data = d; i_dp = dp; i_blink_en = bl;
    cyc(1);
    cs = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!o_frame && n < 200);
    if (!o_frame) check("frame_timeout", 32'(o_frame), 32'd1);
  endtask

  int cnt [4];
  int frames, gap;

  initial begin
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;

    // 1: reset behaviour
    cyc(1);
    check("rst_first_seg", 32'(o_seg), 32'h C0);
    check("rst_first_sel", 32'(o_sel), 32'h E);
    cyc(39);
    check("digit2_lit_sel", 32'(o_sel), 32'h B);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sel", 32'(o_sel), 32'h F);
    check("async_rst_seg", 32'(o_seg), 32'h FF);
    check("async_rst_frame", 32'(o_frame), 32'h 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("post_rst_seg", 32'(o_seg), 32'h C0);
    check("post_rst_sel", 32'(o_sel), 32'h E);

    // 2: write shows up only after the next frame boundary
    write(16'h1234, 4'b0100, 4'b0000);
    wait_frame();
    check("old_before_frame", 32'(o_seg), 32'h C0);
    cyc(1);
    check("d0_seg", 32'(o_seg), 32'h 99);
    check("d0_sel", 32'(o_sel), 32'h E);
    cyc(16);
    check("d1_seg", 32'(o_seg), 32'h B0);
    check("d1_sel", 32'(o_sel), 32'h D);
    cyc(16);
    check("d2_seg", 32'(o_seg), 32'h 24);
    check("d2_sel", 32'(o_sel), 32'h B);
    cyc(16);
    check("d3_seg", 32'(o_seg), 32'h F9);
    check("d3_sel", 32'(o_sel), 32'h 7);

    // 3: write on the exact boundary cycle is deferred one frame
    wait_frame();
    cyc(10);
    write(16'h4321, 4'b0000, 4'b0000);
    cyc(52);
    write(16'h8765, 4'b0001, 4'b0000);
    check("bnd_write_frame", 32'(o_frame), 32'h 1);
    cyc(1);
    check("bnd_old_shadow", 32'(o_seg), 32'h F9);
    wait_frame();
    cyc(1);
    check("bnd_new_data", 32'(o_seg), 32'h 12);

    // 4: leading-zero blanking
    i_blank_lz = 1'b1;
    write(16'h0005, 4'b0000, 4'b0000);
    wait_frame();
    cyc(1);
    check("lz5_d0_seg", 32'(o_seg), 32'h 92);
    cyc(16);
    check("lz5_d1_sel", 32'(o_sel), 32'h F);
    write(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    cyc(1);
    check("lz0_d0_seg", 32'(o_seg), 32'h C0);
    check("lz0_d0_sel", 32'(o_sel), 32'h E);
    cyc(16);
    check("lz0_d1_sel", 32'(o_sel), 32'h F);
    i_blank_lz = 1'b0;

    // 5: PWM at brightness 3 -> 4 of 16 slot cycles per digit
    i_bright = 4'd3;
    write(16'h1234, 4'b0000, 4'b0000);
    wait_frame();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < 64; c++) begin
      cyc(1);
      for (int k = 0; k < 4; k++) if (!o_sel[k]) cnt[k]++;
    end
    for (int k = 0; k < 4; k++) check($sformatf("pwm_cnt%0d", k), 32'(cnt[k]), 32'd4);
    i_bright = 4'd15;

    // 6: blink on digit 1 only, frame period
    write(16'h1234, 4'b0000, 4'b0010);
    wait_frame();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    frames = 0;
    for (int c = 0; c < 128; c++) begin
      cyc(1);
      if (o_frame) frames++;
      for (int k = 0; k < 4; k++) if (!o_sel[k]) cnt[k]++;
    end
    check("blink_d0", 32'(cnt[0]), 32'd32);
    check("blink_d1", 32'(cnt[1]), 32'd16);
    check("blink_d2", 32'(cnt[2]), 32'd32);
    check("blink_d3", 32'(cnt[3]), 32'd32);
    check("frames_128", 32'(frames), 32'd2);
    wait_frame();
    gap = 0;
    do begin
      cyc(1);
      gap++;
    end while (!o_frame && gap < 200);
    check("frame_gap", 32'(gap), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
